squash_game_ctrl: RTL and testbench
===================================

Name: squash_game_ctrl

Overview:
Game-flow controller for solo_squash. Conditions the active-low player pads (pause_n, new_game_n, up_key_n, down_key_n) and sequences the game datapath through idle, new-game, run and paused states. All state changes are aligned to frame boundaries, so the ball/paddle logic and the VGA output never see a mid-frame change. Sits between the GPIO inputs and the game core. The core consumes run, new_game and the paddle controls.

Parameters:
DB_CYCLES, 25000, consecutive stable cycles required to accept a pad level change (1 ms at 25 MHz)
DB_W, 15, debounce counter width; must satisfy 2^DB_W > DB_CYCLES

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
pause_n  input  1  raw pause pad, active-low, asynchronous
new_game_n  input  1  raw new-game pad, active-low, asynchronous
up_key_n  input  1  raw paddle-up pad, active-low, asynchronous
down_key_n  input  1  raw paddle-down pad, active-low, asynchronous
frame_tick  input  1  one-cycle pulse at the start of vertical blanking, from VGA timing
run  output  1  game datapath update enable
new_game  output  1  holds the ball/score reset for one frame
paddle_up  output  1  move paddle up this cycle
paddle_down  output  1  move paddle down this cycle
state  output  2  current state: 0 IDLE, 1 NEWGAME, 2 RUN, 3 PAUSED

Behaviour:
- Reset: state=IDLE. All outputs 0. Sync flops and debounced levels = 1 (released). Counters = 0. Pending requests cleared. Reset asserted at any time, including mid-frame or mid-NEWGAME, takes effect on the next edge.
- Sync: each pad passes through a 2-flop synchroniser.
- Debounce, per pad:
  - Counter increments while the synced level differs from the debounced level.
  - Counter clears when the two levels match.
  - When the counter reaches DB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Any glitch shorter than DB_CYCLES cycles is rejected.
- Press pulse: a one-cycle pulse on each debounced 1->0 transition. Latency from the first low sample at the sync input is DB_CYCLES+2 cycles.
- Pad held through reset: registers as a single press DB_CYCLES+2 cycles after reset deasserts.
- Request latches:
  - A pause or new_game press sets pause_req or ng_req respectively.
  - Both latches are cleared when serviced at a frame_tick.
  - A press arriving in the same cycle as frame_tick is latched and serviced at the following tick, not the current one.
- State transitions occur only on frame_tick cycles; the new state is visible on the next cycle:
  - Any state with ng_req -> NEWGAME. ng_req has priority; pause_req is discarded at the same tick.
  - IDLE without ng_req: stay. pause_req is discarded.
  - NEWGAME -> RUN unconditionally, so NEWGAME lasts exactly one frame.
  - RUN with pause_req -> PAUSED.
  - PAUSED with pause_req -> RUN.
- Outputs, all registered; they update on the same edge the state updates:
  - run = (state==RUN).
  - new_game = (state==NEWGAME).
  - paddle_up = RUN & up held & down not held.
  - paddle_down = RUN & down held & up not held.
  - Both keys held -> both outputs 0.
- Never: run and new_game high together; paddle_up and paddle_down high together.

Optional Feature:
Macro SQUASH_SINGLE_STEP_EN.
- Defined:
  - In PAUSED, an up_key press latches step_req.
  - At the next frame_tick without pause_req or ng_req, run=1 for exactly one frame, then 0 again at the following tick; state stays PAUSED (3).
  - paddle_up and paddle_down stay 0 during the step.
- Undefined: up/down presses in PAUSED are ignored. No step logic is synthesised.

Test Plan:
1. DB_CYCLES=4, reset 3 cycles -> all outputs 0, state=0. new_game_n low 10 cycles, then frame_tick -> state=1, new_game=1 for one whole frame. Next frame_tick -> state=2, run=1, new_game=0.
2. In RUN, pulse pause_n low 3 cycles, 5 times, spaced by 3 high cycles; then 2 frame_ticks -> state stays 2, run=1 (bounce rejected).
3. In RUN, pause_n low 8 cycles -> state stays 2 until frame_tick, then 3 with run=0. Repeat the press -> state=2 after the next tick. A press coincident with the tick is serviced only one tick later.
4. In RUN, press pause then new_game before one tick -> state=1 after the tick, then 2 after the following tick (pause discarded).
5. In RUN:
   - up_key_n low -> paddle_up=1 after DB_CYCLES+3 cycles.
   - up and down both low -> both outputs 0.
   - Enter PAUSED while up held -> paddle_up=0.
6. reset high for 1 cycle mid-frame in RUN -> next cycle state=0 and all outputs 0. With SQUASH_SINGLE_STEP_EN: in PAUSED, press up, then tick -> run=1 for exactly one frame, state=3 throughout.

Source files
------------

// File: rtl/squash_game_ctrl.sv
// Purpose: conditions the four active-low player pads and sequences the game core through IDLE/NEWGAME/RUN/PAUSED.
// Latency: pad press to press pulse is DB_CYCLES+2 cycles; state and outputs change one cycle after a frame_tick edge.
// Backpressure: none; pads and frame_tick are consumed every cycle, and requests wait in latches until the next frame_tick.
//
// Ports:
//   clk, reset                               clock and synchronous active-high reset
//   pause_n, new_game_n, up_key_n,
//   down_key_n                               raw asynchronous active-low pads
//   frame_tick                               one-cycle pulse at the start of vertical blanking
//   run, new_game, paddle_up, paddle_down    registered controls to the game core
//   state                                    0 IDLE, 1 NEWGAME, 2 RUN, 3 PAUSED
// Optional feature macro: SQUASH_SINGLE_STEP_EN (an up press while PAUSED runs the core for one frame).
module squash_game_ctrl #(
    parameter int DB_CYCLES = 25000,
    parameter int DB_W      = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause_n,
    input  logic       new_game_n,
    input  logic       up_key_n,
    input  logic       down_key_n,
    input  logic       frame_tick,
    output logic       run,
    output logic       new_game,
    output logic       paddle_up,
    output logic       paddle_down,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NEWGAME = 2'd1,
        ST_RUN     = 2'd2,
        ST_PAUSED  = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    // Pad index: 0 pause, 1 new_game, 2 up, 3 down. Only the pads that
    // generate requests need edge detection.
`ifdef SQUASH_SINGLE_STEP_EN
    localparam int NPRESS = 3;
`else
    localparam int NPRESS = 2;
`endif

    logic [3:0]        pad_raw;
    logic [3:0]        sync1_q;
    logic [3:0]        sync2_q;
    logic [3:0]        deb_q;
    logic [DB_W-1:0]   cnt_q [4];
    logic [NPRESS-1:0] deb_last_q;
    logic [NPRESS-1:0] press_q;

    logic   pause_req_q;
    logic   ng_req_q;
    state_t state_q;
    state_t state_d;
    logic   run_d;
    logic   new_game_d;
    logic   paddle_up_d;
    logic   paddle_down_d;
    logic   up_held;
    logic   down_held;

`ifdef SQUASH_SINGLE_STEP_EN
    logic step_req_q;
    logic step_q;
    logic step_d;
`endif

    assign pad_raw   = {down_key_n, up_key_n, new_game_n, pause_n};
    assign up_held   = ~deb_q[2];
    assign down_held = ~deb_q[3];
    assign state     = state_q;

    // Synchroniser, debounce and press detection. The press pulse is taken
    // from the delayed debounced level, so it lands one cycle after the flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_last_q <= '1;
            press_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= pad_raw;
            sync2_q    <= sync1_q;
            deb_last_q <= deb_q[NPRESS-1:0];
            press_q    <= deb_last_q & ~deb_q[NPRESS-1:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_MAX) begin
                    cnt_q[i] <= '0;
                    deb_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Request latches: a press coinciding with frame_tick wins over the
    // clear, so it is held for the following tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_req_q <= 1'b0;
            ng_req_q    <= 1'b0;
        end else begin
            if (press_q[0])      pause_req_q <= 1'b1;
            else if (frame_tick) pause_req_q <= 1'b0;
            if (press_q[1])      ng_req_q <= 1'b1;
            else if (frame_tick) ng_req_q <= 1'b0;
        end
    end

`ifdef SQUASH_SINGLE_STEP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            step_req_q <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            if (press_q[2] && state_q == ST_PAUSED) step_req_q <= 1'b1;
            else if (frame_tick)                    step_req_q <= 1'b0;
            step_q <= step_d;
        end
    end
`endif

    // State register and registered outputs share one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            run         <= 1'b0;
            new_game    <= 1'b0;
            paddle_up   <= 1'b0;
            paddle_down <= 1'b0;
        end else begin
            state_q     <= state_d;
            run         <= run_d;
            new_game    <= new_game_d;
            paddle_up   <= paddle_up_d;
            paddle_down <= paddle_down_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef SQUASH_SINGLE_STEP_EN
        step_d = step_q;
`endif
        if (frame_tick) begin
`ifdef SQUASH_SINGLE_STEP_EN
            step_d = 1'b0;
`endif
            if (ng_req_q) begin
                state_d = ST_NEWGAME;
            end else begin
                case (state_q)
                    ST_IDLE:    state_d = ST_IDLE;
                    ST_NEWGAME: state_d = ST_RUN;
                    ST_RUN: begin
                        if (pause_req_q) state_d = ST_PAUSED;
                    end
                    ST_PAUSED: begin
                        if (pause_req_q) state_d = ST_RUN;
`ifdef SQUASH_SINGLE_STEP_EN
                        else             step_d  = step_req_q;
`endif
                    end
                    default:    state_d = ST_IDLE;
                endcase
            end
        end

        run_d = (state_d == ST_RUN);
`ifdef SQUASH_SINGLE_STEP_EN
        run_d = run_d | step_d;
`endif
        new_game_d    = (state_d == ST_NEWGAME);
        paddle_up_d   = (state_d == ST_RUN) & up_held & ~down_held;
        paddle_down_d = (state_d == ST_RUN) & down_held & ~up_held;
    end

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Directed bench for squash_game_ctrl with a short debounce window (DB_CYCLES=4).
// Table of {pad levels, hold cycles, tick, expected outputs} plus hand-written
// sequences for tick-coincident presses, paddle latency, reset and single-step.
module tb_squash_game_ctrl;

    localparam int DB = 4;

    // Packed view {state[1:0], run, new_game, paddle_up, paddle_down}
    localparam logic [5:0] O_IDLE   = 6'b00_0000;
    localparam logic [5:0] O_NG     = 6'b01_0100;
    localparam logic [5:0] O_RUN    = 6'b10_1000;
    localparam logic [5:0] O_RUN_UP = 6'b10_1010;
    localparam logic [5:0] O_RUN_DN = 6'b10_1001;
    localparam logic [5:0] O_PAU    = 6'b11_0000;
    localparam logic [5:0] O_STEP   = 6'b11_1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pads_n;      // {down, up, new_game, pause}
    logic       frame_tick;
    logic       run, new_game, paddle_up, paddle_down;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic [3:0] pads_n;
        int         hold;
        bit         tick;
        logic [5:0] exp;
    } vec_t;

    vec_t tv[$];

    squash_game_ctrl #(.DB_CYCLES(DB), .DB_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .pause_n    (pads_n[0]),
        .new_game_n (pads_n[1]),
        .up_key_n   (pads_n[2]),
        .down_key_n (pads_n[3]),
        .frame_tick (frame_tick),
        .run        (run),
        .new_game   (new_game),
        .paddle_up  (paddle_up),
        .paddle_down(paddle_down),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic press(input int idx);
        pads_n      = 4'b1111;
        pads_n[idx] = 1'b0;
        cyc(10);
        pads_n = 4'b1111;
        cyc(10);
    endtask

    task automatic chk(input string nm, input logic [5:0] exp);
        logic [5:0] got;
        got = {state, run, new_game, paddle_up, paddle_down};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", nm, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic [3:0] p, input int h, input bit t, input logic [5:0] e);
        vec_t v;
        v.nm = nm; v.pads_n = p; v.hold = h; v.tick = t; v.exp = e;
        tv.push_back(v);
    endtask

    initial begin
        add("idle_tick",    4'b1111,  2, 1'b1, O_IDLE);
        add("ng_hold",      4'b1101, 10, 1'b0, O_IDLE);
        add("ng_tick",      4'b1111,  0, 1'b1, O_NG);
        add("ng_frame",     4'b1111, 12, 1'b0, O_NG);
        add("run_enter",    4'b1111,  2, 1'b1, O_RUN);
        for (int k = 0; k < 5; k++) begin
            add("bounce_low",  4'b1110, 3, 1'b0, O_RUN);
            add("bounce_high", 4'b1111, 3, 1'b0, O_RUN);
        end
        add("bounce_tick1", 4'b1111,  4, 1'b1, O_RUN);
        add("bounce_tick2", 4'b1111,  4, 1'b1, O_RUN);
        add("pause_hold",   4'b1110,  8, 1'b0, O_RUN);
        add("pause_rel",    4'b1111, 10, 1'b0, O_RUN);
        add("pause_tick",   4'b1111,  1, 1'b1, O_PAU);
        add("resume_hold",  4'b1110,  8, 1'b0, O_PAU);
        add("resume_tick",  4'b1111, 10, 1'b1, O_RUN);

        reset      = 1'b1;
        pads_n     = 4'b1111;
        frame_tick = 1'b0;
        cyc(3);
        chk("reset_state", O_IDLE);
        reset = 1'b0;
        cyc(1);

        foreach (tv[i]) begin
            pads_n = tv[i].pads_n;
            cyc(tv[i].hold);
            if (tv[i].tick) tick();
            chk(tv[i].nm, tv[i].exp);
        end

        // Press pulse lands in the tick cycle: latched, serviced one tick later.
        pads_n = 4'b1110;
        cyc(DB + 3);
        tick();
        chk("coinc_tick", O_RUN);
        pads_n = 4'b1111;
        cyc(10);
        tick();
        chk("coinc_next", O_PAU);
        press(0);
        tick();
        chk("resume2", O_RUN);

        // new_game beats pause at the same tick; pause is dropped.
        press(0);
        press(1);
        tick();
        chk("ng_over_pause", O_NG);
        tick();
        chk("ng_then_run", O_RUN);
        cyc(3);
        tick();
        chk("pause_discarded", O_RUN);

        // Paddle keys: level visible DB+3 cycles after the pad drops.
        pads_n = 4'b1011;
        cyc(DB + 2);
        chk("up_early", O_RUN);
        cyc(1);
        chk("up_latency", O_RUN_UP);
        pads_n = 4'b0011;
        cyc(10);
        chk("both_keys", O_RUN);
        pads_n = 4'b0111;
        cyc(10);
        chk("down_only", O_RUN_DN);
        pads_n = 4'b1011;
        cyc(10);
        chk("up_again", O_RUN_UP);
        pads_n = 4'b1010;
        cyc(10);
        pads_n = 4'b1011;
        cyc(10);
        tick();
        chk("pause_up_held", O_PAU);
        pads_n = 4'b1111;
        cyc(10);
        press(0);
        tick();
        chk("resume3", O_RUN);

        // One-cycle reset in the middle of a RUN frame.
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_reset", O_IDLE);
        cyc(2);
        tick();
        chk("after_reset_tick", O_IDLE);

        // Up press while paused: single frame of run when stepping is built in.
        press(1);
        tick();
        tick();
        chk("step_run", O_RUN);
        press(0);
        tick();
        chk("step_paused", O_PAU);
        press(2);
        tick();
`ifdef SQUASH_SINGLE_STEP_EN
        chk("step_on", O_STEP);
        cyc(10);
        chk("step_frame", O_STEP);
`else
        chk("step_ignored", O_PAU);
        cyc(10);
        chk("step_ignored_frame", O_PAU);
`endif
        tick();
        chk("step_off", O_PAU);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
